// File: rtl/instr_ctrl.sv
// Instruction control unit: latches one instruction, decodes it, and sequences
// DECODE/EXEC/WB (or ERR) with registered control pulses; one instruction per 4 cycles.
module instr_ctrl #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [15:0]         psr_flags,
  output logic [5:0]          alucont,
  output logic [4:0]          ra1,
  output logic [4:0]          ra2,
  output logic                regwrite,
  output logic                pc_load,
  output logic                done,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ERR} state_t;

  localparam logic [5:0] ALU_AND   = 6'd0;
  localparam logic [5:0] ALU_OR    = 6'd1;
  localparam logic [5:0] ALU_XOR   = 6'd2;
  localparam logic [5:0] ALU_ADD   = 6'd3;
  localparam logic [5:0] ALU_SUB   = 6'd4;
  localparam logic [5:0] ALU_CMP   = 6'd5;
  localparam logic [5:0] ALU_MOV   = 6'd6;
  localparam logic [5:0] ALU_LSH   = 6'd7;
  localparam logic [5:0] ALU_LUI   = 6'd8;
  localparam logic [5:0] ALU_JCOND = 6'd9;
  localparam logic [5:0] ALU_JAL   = 6'd10;

  localparam logic [RETIRE_W-1:0] RET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [15:0] ir;
  logic [5:0]  dec_alu;
  logic        dec_legal;
  logic        cond_ok;

  logic [3:0] ir_op, ir_rd, ir_ext, ir_rs;
  assign ir_op  = ir[15:12];
  assign ir_rd  = ir[11:8];
  assign ir_ext = ir[7:4];
  assign ir_rs  = ir[3:0];

  logic flg_c, flg_l, flg_f, flg_z, flg_n;
  assign flg_c = psr_flags[0];
  assign flg_l = psr_flags[2];
  assign flg_f = psr_flags[5];
  assign flg_z = psr_flags[6];
  assign flg_n = psr_flags[7];

  logic unused_flags;
  assign unused_flags = ^{psr_flags[15:8], psr_flags[4:3], psr_flags[1]};

  assign instr_ready = (state == IDLE);

  always_comb begin
    dec_alu   = ALU_AND;
    dec_legal = 1'b0;
    case (ir_op)
      4'h0: begin
        dec_legal = 1'b1;
        case (ir_ext)
          4'h1:    dec_alu = ALU_AND;
          4'h2:    dec_alu = ALU_OR;
          4'h3:    dec_alu = ALU_XOR;
          4'h5:    dec_alu = ALU_ADD;
          4'h9:    dec_alu = ALU_SUB;
          4'hB:    dec_alu = ALU_CMP;
          4'hD:    dec_alu = ALU_MOV;
          default: dec_legal = 1'b0;
        endcase
      end
      4'h8: begin
        dec_alu   = ALU_LSH;
        dec_legal = (ir_ext == 4'h4);
      end
      4'hF: begin
        dec_alu   = ALU_LUI;
        dec_legal = 1'b1;
      end
      4'h4: begin
        dec_legal = 1'b1;
        case (ir_ext)
          4'hC:    dec_alu = ALU_JCOND;
          4'h8:    dec_alu = ALU_JAL;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Jump condition comes from the rd field, evaluated against flags live in EXEC.
  always_comb begin
    cond_ok = 1'b0;
    case (ir_rd)
      4'h0: cond_ok = flg_z;
      4'h1: cond_ok = ~flg_z;
      4'h2: cond_ok = flg_c;
      4'h3: cond_ok = ~flg_c;
      4'h4: cond_ok = flg_l;
      4'h5: cond_ok = ~flg_l;
      4'h6: cond_ok = flg_n;
      4'h7: cond_ok = ~flg_n;
      4'h8: cond_ok = flg_f;
      4'h9: cond_ok = ~flg_f;
      4'hA: cond_ok = ~flg_l & ~flg_z;
      4'hB: cond_ok = flg_l | flg_z;
      4'hC: cond_ok = ~flg_n & ~flg_z;
      4'hD: cond_ok = flg_n | flg_z;
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ir       <= '0;
      alucont  <= '0;
      ra1      <= '0;
      ra2      <= '0;
      regwrite <= 1'b0;
      pc_load  <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      retired  <= '0;
    end else begin
      regwrite <= 1'b0;
      pc_load  <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            alucont <= dec_alu;
            ra1     <= {1'b0, ir_rd};
            ra2     <= {1'b0, ir_rs};
            state   <= EXEC;
          end else begin
            illegal <= 1'b1;
            state   <= ERR;
          end
        end
        // Pulses are registered here so they are visible for exactly the WB cycle.
        EXEC: begin
          regwrite <= (alucont != ALU_CMP) && (alucont != ALU_JCOND);
          pc_load  <= (alucont == ALU_JAL) || ((alucont == ALU_JCOND) && cond_ok);
          done     <= 1'b1;
          retired  <= retired + RET_ONE;
          state    <= WB;
        end
        WB:      state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
